alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
Parametrised multi-cycle ALU for the datapath. It extends the 8-op single-cycle ALU with the following additions:
- WIDTH generalisation.
- Left and arithmetic shifts, and signed compare.
- Iterative multiply, unsigned divide and unsigned remainder.
- A valid/ready handshake so the control unit can stall on long ops.

Results and flags are registered and held until the consumer accepts them.

Parameters:
WIDTH, 32, operand/result width; power of two, 8..64.
SHW, $clog2(WIDTH), shift-amount bits taken from B[SHW-1:0]; derived, not overridden.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  operands/opcode valid.
in_ready  out  1  block can accept an operation.
A  in  WIDTH  operand A.
B  in  WIDTH  operand B.
ALU_operation  in  4  opcode.
out_valid  out  1  res/zero/ovf valid.
out_ready  in  1  consumer accepts result.
res  out  WIDTH  result.
zero  out  1  res == 0.
ovf  out  1  signed overflow (see Optional Feature).

Behaviour:
Opcodes:
- 0000 and; 0001 or; 0010 add; 0011 xor; 0100 nor.
- 0101 srl; 0110 sub; 0111 sltu (0/1 zero-extended).
- 1000 sll; 1001 sra; 1010 slt (signed, 0/1).
- 1011 mul (low WIDTH bits of A*B); 1100 divu; 1101 remu.
- 1110/1111 illegal: res=0, zero=1, single-cycle.

Arithmetic and width rules:
- All add/sub wrap modulo 2^WIDTH.
- Shifts use B[SHW-1:0] only; upper B bits are ignored.

FSM states: IDLE, BUSY, DONE.
- Reset (async): state=IDLE, res=0, zero=0, ovf=0, out_valid=0, iteration counter=0, internal operand regs=0. in_ready is high in IDLE after reset.
- IDLE: in_ready=1. Transfer happens on in_valid & in_ready at a rising edge.
  - Single-cycle op (all except 1011-1101): res/zero/ovf are registered on that edge and state goes to DONE. out_valid=1 the next cycle (latency 1).
  - Multi-cycle op: A/B/op are latched, counter=WIDTH, state goes to BUSY.
- BUSY: in_ready=0, out_valid=0. Each cycle performs one iteration step and decrements the counter.
  - mul: shift-add, one bit of B per cycle.
  - divu/remu: restoring division, one quotient bit per cycle.
  - When the counter reaches 0, the final result is registered and state goes to DONE. out_valid rises WIDTH+1 cycles after the accept edge.
- DONE: out_valid=1, in_ready=0. res/zero/ovf are held stable until out_valid & out_ready. On that edge state goes to IDLE and out_valid drops. No new op is accepted on the same edge; back-to-back throughput for single-cycle ops is 1 op per 2 cycles.
- Divide by zero: divu res = all ones; remu res = A. This completes in the normal WIDTH+1 latency.
- zero is computed from the final registered res value for every op.
- Reset asserted in BUSY or DONE aborts the operation immediately and returns all outputs to their reset values. A partial result is never presented.
- Inputs A/B/ALU_operation may change freely while in BUSY; the latched copies are used.
- in_valid held high while in_ready=0 has no effect.

Optional Feature:
Macro ALU_MC_OVF_EN.
- Defined: ovf = signed overflow for add (operands same sign, result sign differs) and sub (operands differ in sign, result sign differs from A). ovf=0 for all other ops. It is registered with res.
- Undefined: ovf is tied to 0 and no overflow logic is synthesised. Port list is unchanged.

Test Plan:
1. WIDTH=32; add A=0x7FFFFFFF, B=1, out_ready=1 -> out_valid one cycle after accept, res=0x80000000, zero=0, ovf=1 with ALU_MC_OVF_EN (0 without); then in_ready=1 the following cycle.
2. sra A=0x80000000, B=0x00000024 (shift 4) -> res=0xF8000000. sll with the same B -> res=0. slt A=0xFFFFFFFF, B=1 -> res=1; sltu with the same operands -> res=0.
3. mul A=0x00010003, B=0x00000005 -> out_valid exactly 33 cycles after accept, res=0x0005000F. in_ready=0 throughout; A/B toggled during BUSY do not affect res.
4. divu A=100, B=7 -> res=14. remu A=100, B=7 -> res=2. divu A=5, B=0 -> res=0xFFFFFFFF; remu A=5, B=0 -> res=5. Each completes at 33-cycle latency.
5. out_ready=0 for 10 cycles after an and with A=0xF0, B=0x0F -> res=0 and zero=1 held stable; in_valid ignored. Raise out_ready -> one handshake, then IDLE.
6. Assert rst mid-BUSY during a divu -> out_valid=0 and res=0 immediately. After release, in_ready=1 and a new xor A=0xA5, B=0xFF gives res=0x5A.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift/compare, iterative mul/divu/remu.
// Define ALU_MC_OVF_EN to enable signed overflow on add/sub; otherwise ovf is tied low.
module alu_mc #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] res_q, acc_q, a_q, b_q;
  logic             zero_q, ovf_q, out_valid_q, in_ready_q;
  logic [3:0]       op_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] res_c, sum_c, diff_c;
  logic             ovf_c, multi_c;
  logic [SHW-1:0]   sh_c;

  assign sum_c   = A + B;
  assign diff_c  = A - B;
  assign sh_c    = B[SHW-1:0];
  assign multi_c = (ALU_operation == 4'b1011) || (ALU_operation == 4'b1100) ||
                   (ALU_operation == 4'b1101);

  always_comb begin
    res_c = '0;
    case (ALU_operation)
      4'b0000: res_c = A & B;
      4'b0001: res_c = A | B;
      4'b0010: res_c = sum_c;
      4'b0011: res_c = A ^ B;
      4'b0100: res_c = ~(A | B);
      4'b0101: res_c = A >> sh_c;
      4'b0110: res_c = diff_c;
      4'b0111: res_c = {{(WIDTH-1){1'b0}}, A < B};
      4'b1000: res_c = A << sh_c;
      4'b1001: res_c = $signed(A) >>> sh_c;
      4'b1010: res_c = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      default: res_c = '0;
    endcase
  end

`ifdef ALU_MC_OVF_EN
  always_comb begin
    ovf_c = 1'b0;
    if (ALU_operation == 4'b0010)
      ovf_c = (A[WIDTH-1] == B[WIDTH-1]) && (sum_c[WIDTH-1] != A[WIDTH-1]);
    else if (ALU_operation == 4'b0110)
      ovf_c = (A[WIDTH-1] != B[WIDTH-1]) && (diff_c[WIDTH-1] != A[WIDTH-1]);
  end
`else
  assign ovf_c = 1'b0;
`endif

  // One iteration: mul shifts a_q left / b_q right; div shifts dividend out of a_q into acc_q.
  logic [WIDTH:0]   rsh, rsub;
  logic             ge;
  logic [WIDTH-1:0] acc_n, a_n, b_n, fin;

  assign rsh  = {acc_q, a_q[WIDTH-1]};
  assign rsub = rsh - {1'b0, b_q};
  assign ge   = rsh >= {1'b0, b_q};

  always_comb begin
    acc_n = acc_q;
    a_n   = a_q;
    b_n   = b_q;
    fin   = '0;
    if (op_q == 4'b1011) begin
      acc_n = acc_q + (b_q[0] ? a_q : '0);
      a_n   = a_q << 1;
      b_n   = b_q >> 1;
      fin   = acc_n;
    end else begin
      acc_n = ge ? rsub[WIDTH-1:0] : rsh[WIDTH-1:0];
      a_n   = {a_q[WIDTH-2:0], ge};
      fin   = (op_q == 4'b1100) ? a_n : acc_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      res_q       <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      acc_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          in_ready_q <= 1'b0;
          if (multi_c) begin
            a_q     <= A;
            b_q     <= B;
            op_q    <= ALU_operation;
            acc_q   <= '0;
            cnt_q   <= CW'(WIDTH);
            state_q <= BUSY;
          end else begin
            res_q       <= res_c;
            zero_q      <= (res_c == '0);
            ovf_q       <= ovf_c;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        BUSY: begin
          acc_q <= acc_n;
          a_q   <= a_n;
          b_q   <= b_n;
          cnt_q <= cnt_q - 1'b1;
          // Last step registers the result directly so latency is WIDTH+1.
          if (cnt_q == CW'(1)) begin
            res_q       <= fin;
            zero_q      <= (fin == '0);
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign res       = res_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_alu_mc.sv
// Directed, table-driven bench for alu_mc (WIDTH=32) plus hold/reset corner sequences.
module tb_alu_mc;
  logic        clk = 0, rst = 1;
  logic        in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic [31:0] A = 0, B = 0, res;
  logic [3:0]  op = 0;
  logic        zero, ovf;
  int          tests = 0, fails = 0;

  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALU_operation(op), .out_valid(out_valid),
    .out_ready(out_ready), .res(res), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a, b, res;
    logic        zero, ovf;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(string n, logic [3:0] o, logic [31:0] a, logic [31:0] b,
                              logic [31:0] r, logic ov, int lat);
    vec_t v;
    v.name = n; v.op = o; v.a = a; v.b = b; v.res = r; v.zero = (r == 0);
`ifdef ALU_MC_OVF_EN
    v.ovf = ov;
`else
    v.ovf = 1'b0;
`endif
    v.lat = lat;
    return v;
  endfunction

  // Issue one op, scramble inputs while waiting, check result and handshake back to IDLE.
  task automatic run(input vec_t v);
    int lat;
    bit busy_ok;
    @(negedge clk);
    A = v.a; B = v.b; op = v.op; in_valid = 1;
    chk({v.name, ".in_ready_pre"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    lat = 1; busy_ok = 1;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ok = 0;
      A = $urandom; B = $urandom; op = 4'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    chk({v.name, ".lat"}, lat, v.lat);
    chk({v.name, ".res"}, res, v.res);
    chk({v.name, ".zero"}, zero, v.zero);
    chk({v.name, ".ovf"}, ovf, v.ovf);
    if (v.lat > 1) chk({v.name, ".busy_in_ready"}, busy_ok, 1);
    @(posedge clk); #1;
    chk({v.name, ".ov_drop"}, out_valid, 0);
    chk({v.name, ".in_ready_post"}, in_ready, 1);
  endtask

  initial begin
    vecs.push_back(mk("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1, 1));
    vecs.push_back(mk("sra",     4'b1001, 32'h80000000, 32'h24, 32'hF8000000, 0, 1));
    vecs.push_back(mk("sll",     4'b1000, 32'h80000000, 32'h24, 32'h0, 0, 1));
    vecs.push_back(mk("slt",     4'b1010, 32'hFFFFFFFF, 32'h1, 32'h1, 0, 1));
    vecs.push_back(mk("sltu",    4'b0111, 32'hFFFFFFFF, 32'h1, 32'h0, 0, 1));
    vecs.push_back(mk("srl",     4'b0101, 32'h80000000, 32'h21, 32'h40000000, 0, 1));
    vecs.push_back(mk("or",      4'b0001, 32'hF0, 32'h0F, 32'hFF, 0, 1));
    vecs.push_back(mk("nor",     4'b0100, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 1));
    vecs.push_back(mk("sub",     4'b0110, 32'h5, 32'h7, 32'hFFFFFFFE, 0, 1));
    vecs.push_back(mk("sub_ovf", 4'b0110, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1, 1));
    vecs.push_back(mk("ill_e",   4'b1110, 32'h1234, 32'h5678, 32'h0, 0, 1));
    vecs.push_back(mk("ill_f",   4'b1111, 32'hFFFF, 32'h1, 32'h0, 0, 1));
    vecs.push_back(mk("mul",     4'b1011, 32'h00010003, 32'h5, 32'h0005000F, 0, 33));
    vecs.push_back(mk("mul_neg", 4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 0, 33));
    vecs.push_back(mk("divu",    4'b1100, 32'd100, 32'd7, 32'd14, 0, 33));
    vecs.push_back(mk("remu",    4'b1101, 32'd100, 32'd7, 32'd2, 0, 33));
    vecs.push_back(mk("divu0",   4'b1100, 32'd5, 32'd0, 32'hFFFFFFFF, 0, 33));
    vecs.push_back(mk("remu0",   4'b1101, 32'd5, 32'd0, 32'd5, 0, 33));
    vecs.push_back(mk("remu_ex", 4'b1101, 32'd49, 32'd7, 32'd0, 0, 33));

    #12;
    chk("rst.res", res, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.zero", zero, 0);
    chk("rst.ovf", ovf, 0);
    chk("rst.in_ready", in_ready, 1);
    @(negedge clk); rst = 0;

    foreach (vecs[i]) run(vecs[i]);

    // Consumer stalls: result held, in_valid ignored.
    out_ready = 0;
    @(negedge clk);
    A = 32'hF0; B = 32'h0F; op = 4'b0000; in_valid = 1;
    @(posedge clk); #1;
    A = 32'h1; B = 32'h1; op = 4'b0010;
    begin
      bit hold_ok = 1;
      for (int i = 0; i < 10; i++) begin
        if (!out_valid || res !== 0 || zero !== 1 || in_ready) hold_ok = 0;
        @(posedge clk); #1;
      end
      chk("hold.stable", hold_ok, 1);
    end
    chk("hold.res", res, 0);
    chk("hold.zero", zero, 1);
    in_valid = 0;
    @(negedge clk); out_ready = 1;
    @(posedge clk); #1;
    chk("hold.ov_drop", out_valid, 0);
    chk("hold.in_ready", in_ready, 1);

    // Reset mid-BUSY aborts a divide.
    @(negedge clk);
    A = 32'd100; B = 32'd7; op = 4'b1100; in_valid = 1;
    @(negedge clk); in_valid = 0;
    repeat (10) @(negedge clk);
    chk("abort.busy", in_ready, 0);
    rst = 1; #1;
    chk("abort.out_valid", out_valid, 0);
    chk("abort.res", res, 0);
    chk("abort.in_ready", in_ready, 1);
    @(negedge clk); rst = 0;
    repeat (2) @(negedge clk);
    chk("abort.no_result", out_valid, 0);
    run(mk("xor_after", 4'b0011, 32'hA5, 32'hFF, 32'h5A, 0, 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
